// File: rtl/staff_grid_gen.sv
// rtl/staff_grid_gen.sv - parametrised staff-line painter with row FSM, highlight mask and registered RGB.
// Optional bar lines under STAFF_GRID_BEAT_MARKS_EN.
module staff_grid_gen #(
  parameter int N_LINES = 7,
  parameter int LINE_TOP = 96,
  parameter int LINE_PITCH = 32,
  parameter int LINE_THICK = 2,
  parameter int X_W = 12,
  parameter int Y_W = 11,
  parameter logic [3:0] FG_COLOR = 4'h0,
  parameter logic [3:0] BG_COLOR = 4'hF,
  parameter logic [3:0] HL_COLOR = 4'h8
`ifdef STAFF_GRID_BEAT_MARKS_EN
  ,
  parameter int BEAT_LEFT = 64,
  parameter int BEAT_PITCH = 128
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic               pix_valid,
  input  logic               hl_valid,
  output logic               hl_ready,
  input  logic [N_LINES-1:0] hl_mask,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               vga_valid,
  output logic [3:0]         line_idx
);

  localparam int PH_W = $clog2(LINE_PITCH + 1);

  typedef enum logic [1:0] {ABOVE, LINE, GAP, BELOW} row_state_t;

  row_state_t         state, state_nx;
  logic [PH_W-1:0]    phase, phase_nx;
  logic [3:0]         k, k_nx;
  logic [Y_W-1:0]     y_prev;
  logic [N_LINES-1:0] shadow, active, active_nx;
  logic [15:0]        mask_pad;
  logic               new_row, frame_start, hl_xfer, in_staff, beat_bar;
  logic [3:0]         color, idx;

  assign new_row     = (y != y_prev);
  assign frame_start = (y == '0) && (y_prev != '0);
  assign hl_xfer     = hl_valid && hl_ready;
  assign active_nx   = frame_start ? shadow : active;

  // Row 0 always restarts the walk, so a wrap mid-FSM or LINE_TOP=0 needs no special case.
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    k_nx     = k;
    if (y == '0) begin
      state_nx = (y == Y_W'(LINE_TOP)) ? LINE : ABOVE;
      phase_nx = '0;
      k_nx     = '0;
    end else if (new_row) begin
      case (state)
        ABOVE: begin
          if (y == Y_W'(LINE_TOP)) begin
            state_nx = LINE;
            phase_nx = '0;
            k_nx     = '0;
          end
        end
        LINE: begin
          phase_nx = phase + PH_W'(1);
          if (phase == PH_W'(LINE_THICK - 1)) state_nx = GAP;
        end
        GAP: begin
          if (phase == PH_W'(LINE_PITCH - 1)) begin
            if (k == 4'(N_LINES - 1)) begin
              state_nx = BELOW;
            end else begin
              k_nx     = k + 4'd1;
              phase_nx = '0;
              state_nx = LINE;
            end
          end else begin
            phase_nx = phase + PH_W'(1);
          end
        end
        default: state_nx = BELOW;
      endcase
    end
  end

  assign in_staff = (state_nx == LINE) || ((state_nx == GAP) && (k_nx != 4'(N_LINES - 1)));

`ifdef STAFF_GRID_BEAT_MARKS_EN
  localparam int BC_W = $clog2(BEAT_PITCH);
  logic [BC_W-1:0] col_cnt, col_cur;

  always_comb begin
    col_cur = col_cnt + BC_W'(1);
    if (x == X_W'(BEAT_LEFT) || col_cnt == BC_W'(BEAT_PITCH - 1)) col_cur = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) col_cnt <= '0;
    else          col_cnt <= col_cur;
  end

  assign beat_bar = in_staff && (col_cur == '0);
`else
  logic unused_x;
  assign unused_x = ^{x, in_staff};
  assign beat_bar = 1'b0;
`endif

  always_comb begin
    mask_pad = '0;
    mask_pad[N_LINES-1:0] = active_nx;
    color = BG_COLOR;
    idx   = 4'hF;
    if (pix_valid) begin
      if (state_nx == LINE) begin
        color = mask_pad[k_nx] ? HL_COLOR : FG_COLOR;
        idx   = k_nx;
      end else if (beat_bar) begin
        color = FG_COLOR;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_prev    <= '1;
      state     <= ABOVE;
      phase     <= '0;
      k         <= '0;
      shadow    <= '0;
      active    <= '0;
      hl_ready  <= 1'b1;
      vga_r     <= BG_COLOR;
      vga_g     <= BG_COLOR;
      vga_b     <= BG_COLOR;
      vga_valid <= 1'b0;
      line_idx  <= 4'hF;
    end else begin
      y_prev <= y;
      state  <= state_nx;
      phase  <= phase_nx;
      k      <= k_nx;
      if (hl_xfer) shadow <= hl_mask;
      // A transfer coinciding with the frame copy keeps ready low until the following frame.
      if (hl_xfer)          hl_ready <= 1'b0;
      else if (frame_start) hl_ready <= 1'b1;
      if (frame_start) active <= shadow;
      vga_r     <= color;
      vga_g     <= color;
      vga_b     <= color;
      vga_valid <= pix_valid;
      line_idx  <= idx;
    end
  end

endmodule

// File: tb/tb_staff_grid_gen.sv
// tb/tb_staff_grid_gen.sv - directed table-driven bench for staff_grid_gen (three parameter sets).
module tb_staff_grid_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] x;
  logic [10:0] y;
  logic        pix_valid;
  logic        hl_valid;
  logic [6:0]  hl_mask;

  logic [3:0] r [3];
  logic [3:0] g [3];
  logic [3:0] b [3];
  logic [3:0] li [3];
  logic       vv [3];
  logic       rd [3];

  always #5 clk = ~clk;

  staff_grid_gen dut0 (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .pix_valid(pix_valid),
    .hl_valid(hl_valid), .hl_ready(rd[0]), .hl_mask(hl_mask),
    .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]), .vga_valid(vv[0]), .line_idx(li[0])
  );

  staff_grid_gen #(.N_LINES(5), .LINE_TOP(40), .LINE_PITCH(20), .LINE_THICK(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .pix_valid(pix_valid),
    .hl_valid(1'b0), .hl_ready(rd[1]), .hl_mask(5'd0),
    .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]), .vga_valid(vv[1]), .line_idx(li[1])
  );

  staff_grid_gen #(.N_LINES(2), .LINE_TOP(0), .LINE_PITCH(4), .LINE_THICK(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .pix_valid(pix_valid),
    .hl_valid(1'b0), .hl_ready(rd[2]), .hl_mask(2'd0),
    .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]), .vga_valid(vv[2]), .line_idx(li[2])
  );

  typedef struct {
    int dut;
    int start;
    int thick;
    int idx;
  } line_rec_t;

  line_rec_t tbl [14];
  logic [6:0] exp_mask0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_idx(input int d, input int yy);
    for (int i = 0; i < 14; i++)
      if (tbl[i].dut == d && yy >= tbl[i].start && yy < tbl[i].start + tbl[i].thick)
        return tbl[i].idx;
    return 15;
  endfunction

  function automatic bit in_staff(input int d, input int yy);
    int lo = 100000;
    int hi = -1;
    for (int i = 0; i < 14; i++)
      if (tbl[i].dut == d) begin
        if (tbl[i].start < lo) lo = tbl[i].start;
        if (tbl[i].start + tbl[i].thick - 1 > hi) hi = tbl[i].start + tbl[i].thick - 1;
      end
    return (yy >= lo) && (yy <= hi);
  endfunction

  task automatic apply(input int yy, input int xx, input bit pv);
    @(negedge clk);
    y = 11'(yy);
    x = 12'(xx);
    pix_valid = pv;
    @(posedge clk);
    #1;
  endtask

  task automatic sample_check(input int yy, input bit bg_all, input bit pv_off);
    for (int d = 0; d < 3; d++) begin
      int ei;
      logic [3:0] ec;
      bit skip_col;
      ei = (bg_all || pv_off) ? 15 : exp_idx(d, yy);
      ec = (ei == 15) ? 4'hF : ((d == 0 && exp_mask0[ei]) ? 4'h8 : 4'h0);
      skip_col = 1'b0;
`ifdef STAFF_GRID_BEAT_MARKS_EN
      skip_col = (ei == 15) && !bg_all && !pv_off && in_staff(d, yy);
`endif
      chk($sformatf("d%0d y%0d line_idx", d, yy), 16'(li[d]), 16'(ei));
      if (!skip_col)
        chk($sformatf("d%0d y%0d rgb", d, yy), 16'({r[d], g[d], b[d]}), 16'({ec, ec, ec}));
      chk($sformatf("d%0d y%0d vga_valid", d, yy), 16'(vv[d]), 16'(!pv_off));
    end
  endtask

  task automatic do_row(input int yy, input bit bg_all, input bit pv_off);
    apply(yy, 10, 1'b1);
    apply(yy, 10, !pv_off);
    sample_check(yy, bg_all, pv_off);
  endtask

  task automatic chk_bg_now(input string nm);
    chk({nm, " rgb"}, 16'({r[0], g[0], b[0]}), 16'hFFF);
    chk({nm, " line_idx"}, 16'(li[0]), 16'hF);
    chk({nm, " vga_valid"}, 16'(vv[0]), 16'h0);
    chk({nm, " hl_ready"}, 16'(rd[0]), 16'h1);
    chk({nm, " d1 rgb"}, 16'({r[1], g[1], b[1]}), 16'hFFF);
  endtask

`ifdef STAFF_GRID_BEAT_MARKS_EN
  task automatic beat_sweep(input int yy, input int xa, input logic [3:0] ca);
    for (int xx = 0; xx <= 200; xx++) begin
      apply(yy, xx, 1'b1);
      if (xx == xa) begin
        chk($sformatf("beat y%0d x%0d rgb", yy, xx), 16'({r[0], g[0], b[0]}), 16'({ca, ca, ca}));
        chk($sformatf("beat y%0d x%0d line_idx", yy, xx), 16'(li[0]), 16'hF);
      end
      if (yy == 150 && xx == 65)
        chk("beat x65 rgb", 16'({r[0], g[0], b[0]}), 16'hFFF);
      if (yy == 150 && xx == 192)
        chk("beat x192 rgb", 16'({r[0], g[0], b[0]}), 16'h000);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 7; i++) tbl[i] = '{0, 96 + 32 * i, 2, i};
    tbl[7]  = '{1, 40, 3, 0};
    tbl[8]  = '{1, 60, 3, 1};
    tbl[9]  = '{1, 80, 3, 2};
    tbl[10] = '{1, 100, 3, 3};
    tbl[11] = '{1, 120, 3, 4};
    tbl[12] = '{2, 0, 1, 0};
    tbl[13] = '{2, 4, 1, 1};
    exp_mask0 = 7'b0;

    reset_n = 1'b0;
    hl_valid = 1'b0;
    hl_mask = 7'b0;
    x = 12'd10;
    y = 11'd0;
    pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_bg_now("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Frame 1: mask offered mid-frame, must not take effect yet.
    for (int yy = 0; yy < 480; yy++) begin
      do_row(yy, 1'b0, 1'b0);
      if (yy == 150) begin
        chk("hl_ready before xfer", 16'(rd[0]), 16'h1);
        @(negedge clk);
        hl_valid = 1'b1;
        hl_mask = 7'b0000100;
        @(negedge clk);
        hl_valid = 1'b0;
        chk("hl_ready after xfer", 16'(rd[0]), 16'h0);
`ifdef STAFF_GRID_BEAT_MARKS_EN
        beat_sweep(150, 64, 4'h0);
`endif
      end
`ifdef STAFF_GRID_BEAT_MARKS_EN
      if (yy == 300) beat_sweep(300, 64, 4'hF);
`endif
      if (yy == 300) chk("hl_ready held mid-frame", 16'(rd[0]), 16'h0);
    end

    // Frame 2: mask now active; one line row with pix_valid low.
    exp_mask0 = 7'b0000100;
    for (int yy = 0; yy < 480; yy++) begin
      do_row(yy, 1'b0, yy == 192);
      if (yy == 0) chk("hl_ready after frame", 16'(rd[0]), 16'h1);
    end

    // Frame 3: async reset at row 130, background until the wrap.
    for (int yy = 0; yy < 130; yy++) do_row(yy, 1'b0, 1'b0);
    apply(130, 10, 1'b1);
    chk("pre-reset y130 line_idx", 16'(li[0]), 16'hF);
    #2;
    reset_n = 1'b0;
    #1;
    chk_bg_now("async reset");
    @(negedge clk);
    reset_n = 1'b1;
    exp_mask0 = 7'b0;
    for (int yy = 130; yy < 480; yy++) do_row(yy, 1'b1, 1'b0);

    // Frame 4: clean frame after reset, mask cleared.
    for (int yy = 0; yy < 480; yy++) do_row(yy, 1'b0, 1'b0);
    chk("hl_ready frame4", 16'(rd[0]), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/staff_grid_gen.md
Name: staff_grid_gen

Overview:
Parametrised successor to the fixed 7-line staff painter. Draws N_LINES horizontal staff lines with configurable top offset, pitch and thickness. Row classification is tracked by an incremental row-state machine rather than per-line comparators. Adds a frame-synchronous per-line highlight mask loaded via valid/ready, and a registered RGB output. Sits between the SVGA timing generator (x/y) and the pixel mux.

Parameters:
N_LINES, 7, number of staff lines (1..16)
LINE_TOP, 96, first row of line 0
LINE_PITCH, 32, rows from the start of one line to the start of the next; must be > LINE_THICK
LINE_THICK, 2, rows per line (>=1)
X_W, 12, width of x
Y_W, 11, width of y
FG_COLOR, 4'h0, normal line intensity
BG_COLOR, 4'hF, background intensity
HL_COLOR, 4'h8, highlighted line intensity

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
x  in  X_W  current column from timing generator
y  in  Y_W  current row from timing generator
pix_valid  in  1  active-video qualifier for x/y
hl_valid  in  1  highlight mask offer
hl_ready  out  1  highlight mask accept
hl_mask  in  N_LINES  bit k=1 -> line k drawn in HL_COLOR
vga_r  out  4  red intensity
vga_g  out  4  green intensity
vga_b  out  4  blue intensity
vga_valid  out  1  pix_valid delayed to align with RGB
line_idx  out  4  index of staff line on current pixel; 4'hF if none

Behaviour:
- Reset (reset_n=0, async): vga_r/g/b=BG_COLOR, vga_valid=0, line_idx=4'hF, hl_ready=1, active and shadow masks=0, row FSM=ABOVE, phase=0, k=0, y_prev=all ones.
- Row tracking: y_prev register; a new row is detected when y != y_prev (y_prev is updated every clk). On y==0 (new frame) the FSM is forced to ABOVE, phase=0, k=0.
- FSM (advances only on new-row detection):
  - ABOVE: when y==LINE_TOP -> LINE with phase=0, k=0.
  - LINE: phase++; when phase==LINE_THICK-1 -> GAP.
  - GAP: phase++; when phase==LINE_PITCH-1: if k==N_LINES-1 -> BELOW, else k++, phase=0 -> LINE.
  - BELOW: hold until y==0.
- The state used for pixel classification is the state after the update for the current y, so the row with y==LINE_TOP is already LINE.
- Pixel path: 1-cycle latency; all outputs registered. In LINE, colour = active_mask[k] ? HL_COLOR : FG_COLOR and line_idx=k. Otherwise colour=BG_COLOR and line_idx=4'hF. r=g=b=colour. When pix_valid=0: colour=BG_COLOR, line_idx=4'hF. vga_valid = pix_valid delayed 1 cycle.
- Highlight handshake: transfer when hl_valid && hl_ready; hl_mask goes into the shadow register and hl_ready drops to 0 the next cycle. At the first new-frame detection (y==0 after y_prev!=0), shadow is copied to active and hl_ready returns to 1. The active mask never changes mid-frame. A transfer on the same cycle as the frame copy is captured in shadow and applied next frame.
- Boundaries:
  - Rows past line N_LINES-1's gap stay BELOW.
  - y wrap-around to 0 mid-FSM restarts cleanly.
  - LINE_TOP=0 is legal: the y==0 row enters LINE directly.
  - Reset mid-frame returns to ABOVE; lines are only correct from the next y==LINE_TOP.

Optional Feature:
STAFF_GRID_BEAT_MARKS_EN: adds parameters BEAT_LEFT (default 64) and BEAT_PITCH (default 128), and a column counter that is reset at x==BEAT_LEFT and wraps at BEAT_PITCH-1. On rows between line 0 and the last line (inclusive) where the counter==0, the pixel is FG_COLOR (a vertical bar line) with line_idx=4'hF unless the pixel is also on a staff line. The same 1-cycle latency applies. Without the macro: no column counter, no bar lines, and outputs are identical to the base behaviour.

Test Plan:
- Defaults, sweep y=0..479 with x=10 -> RGB=0 on rows 96-97, 128-129, …, 288-289 (1 cycle later); 4'hF elsewhere; line_idx=0..6 on those rows.
- N_LINES=5, LINE_PITCH=20, LINE_THICK=3, LINE_TOP=40 -> dark rows 40-42, 60-62, 80-82, 100-102, 120-122; row 140 is background.
- Handshake hl_mask=7'b0000100 mid-frame -> hl_ready=0 next cycle; rows 160-161 stay 4'h0 this frame; next frame rows 160-161 are 4'h8; hl_ready=1 after y==0.
- pix_valid=0 on a line row -> RGB=4'hF, vga_valid=0, line_idx=4'hF one cycle later.
- reset_n asserted at y=130 -> outputs BG immediately (async); after release rows 130-289 are background until the y wrap; next frame is correct.
- With STAFF_GRID_BEAT_MARKS_EN: y=150, x=64 and x=192 -> RGB=0; x=65 -> 4'hF; y=300, x=64 -> 4'hF.
